apb_wait_slave: RTL and testbench
=================================

# apb_wait_slave

APB completer with a word-addressed register file, a programmable wait-state counter and error reporting. It sits on the shared APB segment next to the existing slaves, behind the master bridge, and is selected by its own PSEL line. It exercises the master's PREADY stall and PSLVERR paths, which the zero-wait slaves never drive.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_0200: byte address of word 0.
- `DEPTH`, default 64: number of 32-bit words. Power of two, 2..1024.
- `WAIT_CYCLES`, default 2: wait states inserted per transfer, 0..15.
- `ID_VALUE`, default 32'hA5B0_0001: constant value of word 0, which is read-only.

Ports:
- `PCLK`  in  1  single clock; all state updates on its rising edge.
- `PRESETn`  in  1  asynchronous, active-low reset.
- `PSEL`  in  1  slave select.
- `PENABLE`  in  1  access phase.
- `PWRITE`  in  1  1 = write, 0 = read.
- `PADDR`  in  32  byte address.
- `PWDATA`  in  32  write data.
- `PRDATA`  out  32  read data. Valid only while PREADY = 1, otherwise 0.
- `PREADY`  out  1  transfer completes on a rising edge where PSEL & PENABLE & PREADY.
- `PSLVERR`  out  1  error. Valid only while PREADY = 1, otherwise 0.

## Operation
- The FSM has three states: IDLE, WAIT, DONE.
- **IDLE:** on PSEL & !PENABLE (setup phase), capture PADDR, PWRITE, PWDATA and the decoded error flag, then load cnt = WAIT_CYCLES.
  - Go to DONE if WAIT_CYCLES == 0, else go to WAIT.
- **WAIT:** on each edge where PSEL & PENABLE, decrement cnt. When cnt reaches 1 (pre-decrement), go to DONE.
- **DONE:** PREADY = 1. On PSEL & PENABLE, the transfer completes:
  - a write with no error writes the captured data;
  - then go to IDLE.
- Abort: if PSEL = 0 in WAIT or DONE, go to IDLE. Nothing is written and no error is reported.
- Address decode uses off = PADDR − BASE_ADDR as a 32-bit unsigned value and idx = off[31:2]. The error flag is set if any of these holds:
  - PADDR < BASE_ADDR;
  - idx ≥ DEPTH;
  - PADDR[1:0] ≠ 0;
  - PWRITE = 1 and idx == 0.
- Read data:
  - idx == 0 returns ID_VALUE;
  - any other valid index returns mem[idx];
  - an erroring read returns 32'h0.
- Writes are full 32-bit words; there are no byte strobes.
- PADDR, PWRITE and PWDATA are captured at setup. Any change to them during the access phase is ignored.

## Timing
- Setup is in cycle T, with the access phase starting at T+1.
- PREADY is high for exactly one cycle, T+1+WAIT_CYCLES, assuming the master holds PSEL & PENABLE.
- Total transfer length is WAIT_CYCLES+2 cycles.
- PREADY, PRDATA and PSLVERR are all registered outputs, with no combinational path from any input.
- Read data reflects all writes completed before T.
- A write becomes visible to a read whose setup is in the cycle after completion. Back-to-back transfers are supported with no idle cycle between them.
- Asserting PRESETn low at any point, including mid-transfer, has immediate effect:
  - state goes to IDLE and cnt goes to 0;
  - PREADY, PSLVERR and PRDATA go to 0;
  - every mem word clears to 0.
- On release of reset, the first setup phase is accepted on the first rising edge.
- If PENABLE is seen without a preceding setup while in IDLE, it is ignored and PREADY stays 0.

## Structure
- A shared package `apb_pkg` holds:
  - the FSM state encoding (IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2);
  - the APB data and address widths (32).
- Sub-module `apb_addr_decode` is combinational. Inputs: PADDR, PWRITE, BASE_ADDR, DEPTH. Outputs: idx, err. It is reused by later completers.
- The mem array, cnt and FSM live in the top of this block.

## Test plan
- **Reset:** hold PRESETn = 0 for 3 cycles, then read BASE+0x4. Expect PRDATA = 0, PSLVERR = 0, PREADY high in cycle T+3 (WAIT_CYCLES = 2).
- **Write/read:** write 32'hDEAD_BEEF to BASE+0x8, then read it back. Expect 32'hDEAD_BEEF, with PREADY stretching each transfer to 4 cycles. Repeat with WAIT_CYCLES = 0 and expect 2-cycle transfers.
- **Errors:**
  - read BASE+0x100 (idx 64) → PSLVERR = 1, PRDATA = 0;
  - write BASE+0x2 (misaligned) → PSLVERR = 1, no write;
  - write to BASE+0x0 → PSLVERR = 1, and a later read returns 32'hA5B0_0001.
- **Abort:** drop PSEL during a write's WAIT state. PREADY never rises, and a read of the same address returns its old value.
- **Mid-transfer reset:** pulse PRESETn low during a write's WAIT state. All outputs go to 0 asynchronously, and a read after release returns 0.
- **Back-to-back:** write BASE+0xC = 1 then BASE+0x10 = 2 with no idle cycle, then read both back. Expect 1 and 2, and PADDR changes in the access phase are ignored.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths and the completer FSM state encoding.
package apb_pkg;

  localparam int unsigned APB_AW = 32;
  localparam int unsigned APB_DW = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational APB address decode for a word-addressed register window.
// Ports:
//   PADDR  - byte address presented by the master
//   PWRITE - transfer direction (1 = write)
//   idx    - word index within the window (meaningful only when err = 0)
//   err    - below base, beyond DEPTH, misaligned, or a write to read-only word 0
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter logic [APB_AW-1:0] BASE_ADDR = 32'h0000_0200,
  parameter int unsigned       DEPTH     = 64
) (
  input  logic [APB_AW-1:0]        PADDR,
  input  logic                     PWRITE,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     err
);

  localparam int unsigned       IDX_W = $clog2(DEPTH);
  // Byte span of the window; comparing the full offset avoids slicing off[31:2].
  localparam logic [APB_AW-1:0] SPAN  = APB_AW'(DEPTH * 4);

  logic [APB_AW-1:0] off;

  assign off = PADDR - BASE_ADDR;
  assign idx = off[IDX_W+1:2];

  // off < 4 with an aligned, in-range address means word 0.
  assign err = (PADDR < BASE_ADDR)
             | (off >= SPAN)
             | (PADDR[1:0] != 2'b00)
             | (PWRITE & (off < APB_AW'(4)));

endmodule

// File: rtl/apb_wait_slave.sv
// APB completer with a word register file, programmable wait states and PSLVERR.
// Ports:
//   PCLK, PRESETn          - clock, asynchronous active-low reset
//   PSEL, PENABLE, PWRITE  - APB control
//   PADDR, PWDATA          - byte address, write data (captured at setup)
//   PRDATA, PREADY, PSLVERR- registered completer responses
module apb_wait_slave
  import apb_pkg::*;
#(
  parameter logic [APB_AW-1:0] BASE_ADDR   = 32'h0000_0200,
  parameter int unsigned       DEPTH       = 64,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [APB_DW-1:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [APB_AW-1:0] PADDR,
  input  logic [APB_DW-1:0] PWDATA,
  output logic [APB_DW-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  logic [1:0]        state_q,   state_d;
  logic [3:0]        cnt_q,     cnt_d;
  logic [IDX_W-1:0]  idx_q,     idx_d;
  logic              write_q,   write_d;
  logic              err_q,     err_d;
  logic [APB_DW-1:0] wdata_q,   wdata_d;
  logic              pready_q,  pready_d;
  logic              pslverr_q, pslverr_d;
  logic [APB_DW-1:0] prdata_q,  prdata_d;

  logic [APB_DW-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]  dec_idx;
  logic              dec_err;
  logic [IDX_W-1:0]  rd_idx_c;
  logic              rd_err_c;
  logic              rd_write_c;
  logic [APB_DW-1:0] rd_word_c;
  logic              load_done_c;
  logic              mem_we_c;

  apb_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH)
  ) u_decode (
    .PADDR  (PADDR),
    .PWRITE (PWRITE),
    .idx    (dec_idx),
    .err    (dec_err)
  );

  // Response source: live decode when entering DONE straight from setup, else captured.
  always_comb begin
    if (state_q == ST_IDLE) begin
      rd_idx_c   = dec_idx;
      rd_err_c   = dec_err;
      rd_write_c = PWRITE;
    end else begin
      rd_idx_c   = idx_q;
      rd_err_c   = err_q;
      rd_write_c = write_q;
    end
    rd_word_c = (rd_idx_c == '0) ? ID_VALUE : mem_q[rd_idx_c];
  end

  // Next-state, capture and response logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    write_d     = write_q;
    err_d       = err_q;
    wdata_d     = wdata_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    prdata_d    = '0;
    load_done_c = 1'b0;
    mem_we_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          idx_d   = dec_idx;
          write_d = PWRITE;
          err_d   = dec_err;
          wdata_d = PWDATA;
          cnt_d   = WAIT_LD;
          if (WAIT_LD == 4'd0) begin
            state_d     = ST_DONE;
            load_done_c = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (PENABLE) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d     = ST_DONE;
            load_done_c = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (PENABLE) begin
          mem_we_c = write_q & ~err_q;
          state_d  = ST_IDLE;
        end else begin
          // Master has not entered access yet: keep presenting the response.
          pready_d  = 1'b1;
          pslverr_d = pslverr_q;
          prdata_d  = prdata_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (load_done_c) begin
      pready_d  = 1'b1;
      pslverr_d = rd_err_c;
      prdata_d  = (rd_err_c || rd_write_c) ? '0 : rd_word_c;
    end
  end

  // Control and response registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      err_q     <= err_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Register file; word 0 is never written (reads return ID_VALUE).
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we_c) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_wait_slave.sv
// Directed bench: one completer with 2 wait states (a) and one with none (b).
module tb_apb_wait_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel_a, psel_b, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd;
  logic        er;
  int          cyc;

  always #5 clk = ~clk;

  apb_wait_slave #(.WAIT_CYCLES(2)) dut_a (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel_a), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a)
  );

  apb_wait_slave #(.WAIT_CYCLES(0)) dut_b (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel_b), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at #1 after an edge; ends #1 after the completing edge with PSEL still high.
  task automatic xfer(input bit use_b, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit scramble,
                      output logic [31:0] rdata, output logic err, output int cycles);
    bit done;
    psel_a  = !use_b;
    psel_b  = use_b;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    cycles  = 1;
    rdata   = 'x;
    err     = 1'bx;
    done    = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    cycles  = 2;
    if (scramble) begin
      paddr  = addr ^ 32'h0000_0004;
      pwrite = !wr;
      pwdata = ~wdata;
    end
    for (int k = 0; k < 20 && !done; k++) begin
      if (use_b ? pready_b : pready_a) begin
        rdata = use_b ? prdata_b : prdata_a;
        err   = use_b ? pslverr_b : pslverr_a;
        done  = 1'b1;
      end
      @(posedge clk); #1;
      if (!done) cycles++;
    end
    chk("xfer_completed", 32'(done), 32'd1);
  endtask

  task automatic idle();
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0;

    // Reset held 3 cycles; first setup on first edge after release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", 32'(pready_a), 32'd0);
    chk("rst_prdata", prdata_a, 32'h0);
    rst_n = 1'b1;
    xfer(0, 0, 32'h204, 0, 0, rd, er, cyc);
    chk("rst_rd_data", rd, 32'h0);
    chk("rst_rd_err", 32'(er), 32'd0);
    chk("rst_rd_cyc", 32'(cyc), 32'd4);
    idle();

    // Write/read with 2 wait states
    xfer(0, 1, 32'h208, 32'hDEAD_BEEF, 0, rd, er, cyc);
    chk("w2_wr_err", 32'(er), 32'd0);
    chk("w2_wr_cyc", 32'(cyc), 32'd4);
    idle();
    xfer(0, 0, 32'h208, 0, 0, rd, er, cyc);
    chk("w2_rd_data", rd, 32'hDEAD_BEEF);
    chk("w2_rd_cyc", 32'(cyc), 32'd4);
    idle();

    // Write/read with zero wait states
    xfer(1, 1, 32'h208, 32'hCAFE_F00D, 0, rd, er, cyc);
    chk("w0_wr_cyc", 32'(cyc), 32'd2);
    chk("w0_wr_err", 32'(er), 32'd0);
    idle();
    xfer(1, 0, 32'h208, 0, 0, rd, er, cyc);
    chk("w0_rd_data", rd, 32'hCAFE_F00D);
    chk("w0_rd_cyc", 32'(cyc), 32'd2);
    idle();

    // Error cases
    xfer(0, 0, 32'h300, 0, 0, rd, er, cyc);
    chk("oob_err", 32'(er), 32'd1);
    chk("oob_data", rd, 32'h0);
    idle();
    xfer(0, 0, 32'h1FC, 0, 0, rd, er, cyc);
    chk("below_base_err", 32'(er), 32'd1);
    idle();
    xfer(0, 1, 32'h20A, 32'h1111_1111, 0, rd, er, cyc);
    chk("misalign_err", 32'(er), 32'd1);
    idle();
    xfer(0, 0, 32'h208, 0, 0, rd, er, cyc);
    chk("misalign_nowrite", rd, 32'hDEAD_BEEF);
    idle();
    xfer(0, 1, 32'h200, 32'h0000_FFFF, 0, rd, er, cyc);
    chk("id_wr_err", 32'(er), 32'd1);
    idle();
    xfer(0, 0, 32'h200, 0, 0, rd, er, cyc);
    chk("id_rd_data", rd, 32'hA5B0_0001);
    chk("id_rd_err", 32'(er), 32'd0);
    idle();

    // Abort: drop PSEL while waiting
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h208; pwdata = 32'h1234_5678;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    chk("abort_wait_pready", 32'(pready_a), 32'd0);
    psel_a = 1'b0; penable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("abort_pready", 32'(pready_a), 32'd0);
    end
    xfer(0, 0, 32'h208, 0, 0, rd, er, cyc);
    chk("abort_old_value", rd, 32'hDEAD_BEEF);
    idle();

    // Back-to-back with access-phase address/data disturbance
    xfer(0, 1, 32'h20C, 32'h1, 1, rd, er, cyc);
    chk("b2b_wr1_cyc", 32'(cyc), 32'd4);
    xfer(0, 1, 32'h210, 32'h2, 1, rd, er, cyc);
    chk("b2b_wr2_cyc", 32'(cyc), 32'd4);
    xfer(0, 0, 32'h20C, 0, 1, rd, er, cyc);
    chk("b2b_rd1", rd, 32'h1);
    xfer(0, 0, 32'h210, 0, 1, rd, er, cyc);
    chk("b2b_rd2", rd, 32'h2);
    idle();

    // PENABLE without setup is ignored
    psel_a = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h208;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("no_setup_pready", 32'(pready_a), 32'd0);
    end
    idle();

    // Mid-transfer reset: a waiting, b presenting a response
    psel_a = 1'b1; psel_b = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h208;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("mid_b_pready_pre", 32'(pready_b), 32'd1);
    chk("mid_b_prdata_pre", prdata_b, 32'hCAFE_F00D);
    chk("mid_a_pready_pre", 32'(pready_a), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_b_pready", 32'(pready_b), 32'd0);
    chk("mid_b_prdata", prdata_b, 32'h0);
    chk("mid_b_pslverr", 32'(pslverr_b), 32'd0);
    chk("mid_a_pready", 32'(pready_a), 32'd0);
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    xfer(0, 0, 32'h208, 0, 0, rd, er, cyc);
    chk("post_rst_a_208", rd, 32'h0);
    xfer(0, 0, 32'h20C, 0, 0, rd, er, cyc);
    chk("post_rst_a_20c", rd, 32'h0);
    idle();
    xfer(1, 0, 32'h208, 0, 0, rd, er, cyc);
    chk("post_rst_b_208", rd, 32'h0);
    idle();
    xfer(0, 0, 32'h200, 0, 0, rd, er, cyc);
    chk("post_rst_id", rd, 32'hA5B0_0001);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
